// File: rtl/rv32i_core.sv
// rv32i_core: single-cycle RV32I core, Harvard split, one instruction per clock.
// Ports: clk, rst (async active-low), romout/romaddr (instr), memout/memaddr/memin/memwrite/iobytes (data).
module rv32i_core (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] romout,
   input  logic [31:0] memout,
   output logic [31:0] romaddr,
   output logic [31:0] memaddr,
   output logic [31:0] memin,
   output logic        memwrite,
   output logic [3:0]  iobytes
);

   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_AUIPC = 7'h17;
   localparam logic [6:0] OPC_JAL   = 7'h6f;
   localparam logic [6:0] OPC_JALR  = 7'h67;
   localparam logic [6:0] OPC_BR    = 7'h63;
   localparam logic [6:0] OPC_LD    = 7'h03;
   localparam logic [6:0] OPC_ST    = 7'h23;
   localparam logic [6:0] OPC_OPI   = 7'h13;
   localparam logic [6:0] OPC_OP    = 7'h33;

   logic [31:0] r_pc;
   logic [31:0] r_rf [32];

   logic [6:0]  w_op;
   logic [4:0]  w_rd;
   logic [2:0]  w_f3;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [6:0]  w_f7;

   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;

   logic [31:0] w_rs1v;
   logic [31:0] w_rs2v;

   logic        w_lui;
   logic        w_auipc;
   logic        w_jal;
   logic        w_jalr;
   logic        w_br;
   logic        w_ld;
   logic        w_st;
   logic        w_opi;
   logic        w_opr;

   logic [31:0] w_alu_b;
   logic [4:0]  w_shamt;
   logic        w_sub;
   logic [31:0] w_alu;

   logic        w_cmp;
   logic        w_take;
   logic [31:0] w_pc4;
   logic [31:0] w_npc;

   logic [3:0]  w_lanes;
   logic [31:0] w_din;
   logic [31:0] w_sh;
   logic [31:0] w_ld_data;

   logic        w_we;
   logic [31:0] w_wb;

   assign w_op  = romout[6:0];
   assign w_rd  = romout[11:7];
   assign w_f3  = romout[14:12];
   assign w_rs1 = romout[19:15];
   assign w_rs2 = romout[24:20];
   assign w_f7  = romout[31:25];

   assign w_imm_i = {{20{romout[31]}}, romout[31:20]};
   assign w_imm_s = {{20{romout[31]}}, romout[31:25],
                     romout[11:7]};
   assign w_imm_b = {{19{romout[31]}}, romout[31],
                     romout[7], romout[30:25],
                     romout[11:8], 1'b0};
   assign w_imm_u = {romout[31:12], 12'h000};
   assign w_imm_j = {{11{romout[31]}}, romout[31],
                     romout[19:12], romout[20],
                     romout[30:21], 1'b0};

   assign w_rs1v = (w_rs1 == 5'd0) ? 32'h0 : r_rf[w_rs1];
   assign w_rs2v = (w_rs2 == 5'd0) ? 32'h0 : r_rf[w_rs2];

   // Encodings outside RV32I (bad funct3/funct7) fall through as NOP.
   always_comb begin : decode
      w_lui   = 1'b0;
      w_auipc = 1'b0;
      w_jal   = 1'b0;
      w_jalr  = 1'b0;
      w_br    = 1'b0;
      w_ld    = 1'b0;
      w_st    = 1'b0;
      w_opi   = 1'b0;
      w_opr   = 1'b0;
      unique case (w_op)
         OPC_LUI:   w_lui   = 1'b1;
         OPC_AUIPC: w_auipc = 1'b1;
         OPC_JAL:   w_jal   = 1'b1;
         OPC_JALR:  w_jalr  = (w_f3 == 3'b000);
         OPC_BR:    w_br    = (w_f3[2:1] != 2'b01);
         OPC_LD:    w_ld    = (w_f3 != 3'b011) &&
                              (w_f3[2:1] != 2'b11);
         OPC_ST:    w_st    = !w_f3[2] &&
                              (w_f3[1:0] != 2'b11);
         OPC_OPI: begin
            if (w_f3 == 3'b001)
               w_opi = (w_f7 == 7'h00);
            else if (w_f3 == 3'b101)
               w_opi = ({w_f7[6], w_f7[4:0]} == 6'h00);
            else
               w_opi = 1'b1;
         end
         OPC_OP: begin
            w_opr = (w_f7 == 7'h00) ||
                    ((w_f7 == 7'h20) &&
                     ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
         end
         default: ;
      endcase
   end

   // Loads/JALR use I-imm, stores S-imm, so memaddr is rs1+imm for both.
   assign w_alu_b = w_opr ? w_rs2v :
                    (w_st ? w_imm_s : w_imm_i);
   assign w_shamt = w_alu_b[4:0];
   assign w_sub   = w_opr & w_f7[5];

   always_comb begin : alu
      w_alu = w_rs1v + w_alu_b;
      if (w_opi || w_opr) begin
         unique case (w_f3)
            3'b000: w_alu = w_sub ? (w_rs1v - w_alu_b)
                                  : (w_rs1v + w_alu_b);
            3'b001: w_alu = w_rs1v << w_shamt;
            3'b010: w_alu = {31'b0,
                             $signed(w_rs1v) < $signed(w_alu_b)};
            3'b011: w_alu = {31'b0, w_rs1v < w_alu_b};
            3'b100: w_alu = w_rs1v ^ w_alu_b;
            3'b101: w_alu = w_f7[5]
                            ? $unsigned($signed(w_rs1v) >>> w_shamt)
                            : (w_rs1v >> w_shamt);
            3'b110: w_alu = w_rs1v | w_alu_b;
            3'b111: w_alu = w_rs1v & w_alu_b;
            default: ;
         endcase
      end
   end

   // funct3[0] inverts the base compare (BNE/BGE/BGEU).
   always_comb begin : branch
      w_cmp = 1'b0;
      unique case (w_f3[2:1])
         2'b00:   w_cmp = (w_rs1v == w_rs2v);
         2'b10:   w_cmp = ($signed(w_rs1v) < $signed(w_rs2v));
         2'b11:   w_cmp = (w_rs1v < w_rs2v);
         default: w_cmp = 1'b0;
      endcase
      w_take = w_br & (w_cmp ^ w_f3[0]);
   end

   assign w_pc4 = r_pc + 32'd4;

   always_comb begin : next_pc
      w_npc = w_pc4;
      if (w_jal)
         w_npc = r_pc + w_imm_j;
      else if (w_jalr)
         w_npc = w_alu & ~32'h1;
      else if (w_take)
         w_npc = r_pc + w_imm_b;
   end

   // Lane enables, store replication and load alignment by size.
   always_comb begin : lanes
      w_lanes   = 4'b1111;
      w_din     = w_rs2v;
      w_sh      = memout;
      w_ld_data = w_sh;
      unique case (w_f3[1:0])
         2'b00: begin
            w_lanes   = 4'b0001 << w_alu[1:0];
            w_din     = {4{w_rs2v[7:0]}};
            w_sh      = memout >> {w_alu[1:0], 3'b000};
            w_ld_data = w_f3[2] ? {24'h0, w_sh[7:0]}
                                : {{24{w_sh[7]}}, w_sh[7:0]};
         end
         2'b01: begin
            w_lanes   = w_alu[1] ? 4'b1100 : 4'b0011;
            w_din     = {2{w_rs2v[15:0]}};
            w_sh      = memout >> {w_alu[1], 4'b0000};
            w_ld_data = w_f3[2] ? {16'h0, w_sh[15:0]}
                                : {{16{w_sh[15]}}, w_sh[15:0]};
         end
         default: ;
      endcase
   end

   always_comb begin : writeback
      w_wb = w_alu;
      if (w_lui)
         w_wb = w_imm_u;
      else if (w_auipc)
         w_wb = r_pc + w_imm_u;
      else if (w_jal || w_jalr)
         w_wb = w_pc4;
      else if (w_ld)
         w_wb = w_ld_data;
      w_we = (w_lui | w_auipc | w_jal | w_jalr |
              w_ld | w_opi | w_opr) & (w_rd != 5'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= 32'h0;
         for (int i = 0; i < 32; i++)
            r_rf[i] <= 32'h0;
      end else begin
         r_pc <= w_npc;
         if (w_we)
            r_rf[w_rd] <= w_wb;
      end
   end

   assign romaddr  = r_pc;
   assign memaddr  = w_alu;
   assign memin    = w_din;
   // Gated by rst so an in-flight store drops the moment reset asserts.
   assign memwrite = rst & w_st;
   assign iobytes  = (rst & (w_ld | w_st)) ? w_lanes : 4'b0000;

endmodule

// File: tb/tb_rv32i_core.sv
// tb_rv32i_core: directed + random self-checking bench for rv32i_core.
// Drives romout/memout per cycle and checks against an ISA-level model.
module tb_rv32i_core;

   logic        clk;
   logic        rst;
   logic [31:0] romout;
   logic [31:0] memout;
   logic [31:0] romaddr;
   logic [31:0] memaddr;
   logic [31:0] memin;
   logic        memwrite;
   logic [3:0]  iobytes;

   int n_cmp;
   int n_err;

   logic [31:0] m_pc;
   logic [31:0] m_x [32];

   logic [31:0] o_addr;
   logic [31:0] o_din;
   logic [3:0]  o_be;
   logic        o_we;

   rv32i_core dut (
      .clk      (clk),
      .rst      (rst),
      .romout   (romout),
      .memout   (memout),
      .romaddr  (romaddr),
      .memaddr  (memaddr),
      .memin    (memin),
      .memwrite (memwrite),
      .iobytes  (iobytes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(
      input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_i(
      input logic [31:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(
      input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(
      input logic [31:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3,
              imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(
      input logic [31:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
      return {imm[19:0], rd, op};
   endfunction

   function automatic logic [31:0] enc_j(
      input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12],
              rd, 7'h6f};
   endfunction

   function automatic logic [31:0] alu(
      input logic [2:0] f, input logic alt,
      input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0: return alt ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
         3'd3: return (a < b) ? 1 : 0;
         3'd4: return a ^ b;
         3'd5: return alt ? 32'($signed(a) >>> b[4:0])
                          : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   // ISA-level model of one instruction against m_pc/m_x.
   task automatic model(
      input  logic [31:0] ins, input logic [31:0] mo,
      output logic [31:0] npc, output logic we,
      output logic [31:0] wb, output logic ca,
      output logic [31:0] addr, output logic st,
      output logic [3:0] be, output logic [31:0] din);
      logic [31:0] a, b, ii, is, ib, iu, ij;
      logic [7:0] by [4];
      logic [2:0] f3;
      int k;
      npc = m_pc + 4; we = 0; wb = 0; ca = 0;
      addr = 0; st = 0; be = 0; din = 0;
      f3 = ins[14:12];
      a  = m_x[ins[19:15]];
      b  = m_x[ins[24:20]];
      ii = 32'($signed(ins[31:20]));
      is = 32'($signed({ins[31:25], ins[11:7]}));
      ib = 32'($signed({ins[31], ins[7], ins[30:25],
                        ins[11:8], 1'b0}));
      iu = {ins[31:12], 12'h0};
      ij = 32'($signed({ins[31], ins[19:12], ins[20],
                        ins[30:21], 1'b0}));
      for (int j = 0; j < 4; j++) by[j] = mo[8*j +: 8];
      case (ins[6:0])
         7'h37: begin we = 1; wb = iu; end
         7'h17: begin we = 1; wb = m_pc + iu; end
         7'h6f: begin
            we = 1; wb = m_pc + 4; npc = m_pc + ij;
         end
         7'h67: begin
            we = 1; wb = m_pc + 4;
            npc = (a + ii) & ~32'h1;
         end
         7'h63: begin
            logic t;
            case (f3)
               3'd0: t = (a == b);
               3'd1: t = (a != b);
               3'd4: t = ($signed(a) < $signed(b));
               3'd5: t = ($signed(a) >= $signed(b));
               3'd6: t = (a < b);
               default: t = (a >= b);
            endcase
            if (t) npc = m_pc + ib;
         end
         7'h03: begin
            ca = 1; we = 1; addr = a + ii;
            k = int'(addr[1:0]);
            case (f3)
               3'd0: begin
                  be = 4'(1 << k);
                  wb = 32'($signed(by[k]));
               end
               3'd4: begin
                  be = 4'(1 << k); wb = {24'h0, by[k]};
               end
               3'd1, 3'd5: begin
                  k = addr[1] ? 2 : 0;
                  be = 4'(3 << k);
                  wb = {16'h0, by[k+1], by[k]};
                  if (f3 == 3'd1)
                     wb = 32'($signed(wb[15:0]));
               end
               default: begin be = 4'hF; wb = mo; end
            endcase
         end
         7'h23: begin
            ca = 1; st = 1; addr = a + is;
            case (f3)
               3'd0: begin
                  be = 4'(1 << addr[1:0]);
                  din = {4{b[7:0]}};
               end
               3'd1: begin
                  be = addr[1] ? 4'hC : 4'h3;
                  din = {2{b[15:0]}};
               end
               default: begin be = 4'hF; din = b; end
            endcase
         end
         7'h13: begin
            ca = 1; we = 1;
            wb = alu(f3, (f3 == 3'd5) & ins[30], a, ii);
            addr = wb;
         end
         7'h33: begin
            ca = 1; we = 1;
            wb = alu(f3, ins[30], a, b);
            addr = wb;
         end
         default: ;
      endcase
   endtask

   // Starts and ends at a falling edge; one instruction per call.
   task automatic step(input logic [31:0] ins,
                       input logic [31:0] mo);
      logic [31:0] e_npc, e_wb, e_addr, e_din;
      logic [3:0] e_be;
      logic e_we, e_ca, e_st;
      romout = ins;
      memout = mo;
      #1;
      model(ins, mo, e_npc, e_we, e_wb, e_ca,
            e_addr, e_st, e_be, e_din);
      chk("romaddr", romaddr, m_pc);
      chk("memwrite", {31'b0, memwrite}, {31'b0, e_st});
      chk("iobytes", {28'b0, iobytes}, {28'b0, e_be});
      if (e_ca) chk("memaddr", memaddr, e_addr);
      if (e_st) chk("memin", memin, e_din);
      o_addr = memaddr;
      o_din  = memin;
      o_be   = iobytes;
      o_we   = memwrite;
      @(posedge clk);
      m_pc = e_npc;
      if (e_we && ins[11:7] != 5'd0) m_x[ins[11:7]] = e_wb;
      @(negedge clk);
   endtask

   task automatic rdreg(input logic [4:0] r,
                        output logic [31:0] v);
      step(enc_i(0, r, 3'd0, 5'd0, 7'h13), $urandom);
      v = o_addr;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      romout = $urandom;
      memout = $urandom;
      #1;
      chk("rst_romaddr", romaddr, 32'h0);
      chk("rst_memwrite", {31'b0, memwrite}, 32'h0);
      chk("rst_iobytes", {28'b0, iobytes}, 32'h0);
      @(negedge clk);
      romout = enc_s(0, 5'd1, 5'd0, 3'd2);
      #1;
      chk("rsthold_romaddr", romaddr, 32'h0);
      chk("rsthold_memwrite", {31'b0, memwrite}, 32'h0);
      rst = 1'b1;
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_x[i] = 0;
   endtask

   function automatic logic [31:0] rand_ins();
      logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      logic [2:0] brf [6] = '{3'd0, 3'd1, 3'd4, 3'd5,
                              3'd6, 3'd7};
      logic [31:0] r;
      logic [4:0] rd, s1, s2;
      logic [2:0] f3;
      logic [6:0] f7;
      r  = $urandom;
      rd = 5'($urandom);
      s1 = 5'($urandom);
      s2 = 5'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 9))
         0: return enc_u(r, rd, 7'h37);
         1: return enc_u(r, rd, 7'h17);
         2: return enc_j(r & ~32'h1, rd);
         3: return enc_i(r, s1, 3'd0, rd, 7'h67);
         4: return enc_b(r, s2, s1,
                         brf[$urandom_range(0, 5)]);
         5: return enc_i(r, s1, ldf[$urandom_range(0, 4)],
                         rd, 7'h03);
         6: return enc_s(r, s2, s1, 3'($urandom_range(0, 2)));
         7, 8: begin
            if (f3 == 3'd1) r[11:5] = 7'h00;
            if (f3 == 3'd5) r[11:5] = r[0] ? 7'h20 : 7'h00;
            return enc_i(r, s1, f3, rd, 7'h13);
         end
         default: begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[0])
                 ? 7'h20 : 7'h00;
            return enc_r(f7, s2, s1, f3, rd, 7'h33);
         end
      endcase
   endfunction

   initial begin
      logic [31:0] v;
      logic [31:0] p;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      romout = 32'h13;
      memout = 32'h0;
      #2;
      do_reset();

      // Stack program from reset.
      step(enc_i(-4, 5'd2, 3'd2, 5'd8, 7'h03), 32'hABCD4321);
      chk("lw_addr", o_addr, 32'hFFFFFFFC);
      chk("lw_be", {28'b0, o_be}, 32'hF);
      step(enc_i(-4, 5'd2, 3'd0, 5'd2, 7'h13), 32'h0);
      step(enc_i(16, 5'd8, 3'd1, 5'd5, 7'h13), 32'h0);
      step(enc_s(-4, 5'd5, 5'd2, 3'd2), 32'h0);
      chk("sw1_addr", o_addr, 32'hFFFFFFF8);
      chk("sw1_din", o_din, 32'h43210000);
      chk("sw1_we", {31'b0, o_we}, 32'h1);
      step(enc_i(-4, 5'd2, 3'd0, 5'd2, 7'h13), 32'h0);
      step(enc_u(32'hFFFF0, 5'd9, 7'h37), 32'h0);
      step(enc_r(7'h0, 5'd9, 5'd8, 3'd7, 5'd5, 7'h33), 32'h0);
      step(enc_s(-4, 5'd5, 5'd2, 3'd2), 32'h0);
      chk("sw2_addr", o_addr, 32'hFFFFFFF4);
      chk("sw2_din", o_din, 32'hABCD0000);
      step(enc_i(-4, 5'd2, 3'd0, 5'd2, 7'h13), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(enc_j(0, 5'd0), 32'h0);
         chk("jal_hold", romaddr, 32'h24);
      end
      rdreg(5'd8, v);
      chk("s0", v, 32'hABCD4321);

      // Byte/half stores.
      step(enc_u(32'h11223, 5'd5, 7'h37), 0);
      step(enc_i(32'h344, 5'd5, 3'd0, 5'd5, 7'h13), 0);
      step(enc_s(3, 5'd5, 5'd0, 3'd0), 0);
      chk("sb_be", {28'b0, o_be}, 32'h8);
      chk("sb_din", {24'b0, o_din[31:24]}, 32'h44);
      step(enc_s(2, 5'd5, 5'd0, 3'd1), 0);
      chk("sh_be", {28'b0, o_be}, 32'hC);
      chk("sh_din", {16'b0, o_din[31:16]}, 32'h3344);

      // Loads.
      step(enc_i(2, 5'd0, 3'd0, 5'd6, 7'h03), 32'h80FF7F01);
      rdreg(5'd6, v);
      chk("lb", v, 32'hFFFFFFFF);
      step(enc_i(3, 5'd0, 3'd4, 5'd6, 7'h03), 32'h80FF7F01);
      rdreg(5'd6, v);
      chk("lbu", v, 32'h80);
      step(enc_i(2, 5'd0, 3'd1, 5'd6, 7'h03), 32'h80FF7F01);
      rdreg(5'd6, v);
      chk("lh", v, 32'hFFFF80FF);
      step(enc_i(0, 5'd0, 3'd5, 5'd6, 7'h03), 32'h80FF7F01);
      rdreg(5'd6, v);
      chk("lhu", v, 32'h7F01);

      // Branches.
      step(enc_i(-1, 5'd0, 3'd0, 5'd7, 7'h13), 0);
      step(enc_i(1, 5'd0, 3'd0, 5'd8, 7'h13), 0);
      p = m_pc;
      step(enc_b(8, 5'd8, 5'd7, 3'd4), 0);
      chk("blt_taken", romaddr, p + 8);
      p = m_pc;
      step(enc_b(8, 5'd8, 5'd7, 3'd6), 0);
      chk("bltu_not", romaddr, p + 4);

      // JALR from 0x10.
      do_reset();
      step(enc_i(32'h21, 5'd0, 3'd0, 5'd10, 7'h13), 0);
      for (int i = 0; i < 3; i++) step(32'h13, 0);
      step(enc_i(0, 5'd10, 3'd0, 5'd11, 7'h67), 0);
      chk("jalr_pc", romaddr, 32'h20);
      rdreg(5'd11, v);
      chk("jalr_link", v, 32'h14);
      step(enc_i(5, 5'd0, 3'd0, 5'd0, 7'h13), 0);
      step(enc_u(32'h12345, 5'd0, 7'h37), 0);
      rdreg(5'd0, v);
      chk("x0", v, 32'h0);

      // ALU corners.
      step(enc_u(32'h80000, 5'd12, 7'h37), 0);
      step(enc_i(4, 5'd0, 3'd0, 5'd14, 7'h13), 0);
      step(enc_r(7'h20, 5'd14, 5'd12, 3'd5, 5'd13, 7'h33), 0);
      rdreg(5'd13, v);
      chk("sra", v, 32'hF8000000);
      step(enc_i(1, 5'd0, 3'd0, 5'd15, 7'h13), 0);
      step(enc_r(7'h20, 5'd15, 5'd0, 3'd0, 5'd13, 7'h33), 0);
      rdreg(5'd13, v);
      chk("sub", v, 32'hFFFFFFFF);
      step(enc_i(-5, 5'd0, 3'd0, 5'd16, 7'h13), 0);
      step(enc_i(-4, 5'd16, 3'd2, 5'd13, 7'h13), 0);
      rdreg(5'd13, v);
      chk("slti", v, 32'h1);

      // AUIPC at 0x8, then reset mid-store.
      do_reset();
      step(32'h13, 0);
      step(32'h13, 0);
      step(enc_u(1, 5'd13, 7'h17), 0);
      rdreg(5'd13, v);
      chk("auipc", v, 32'h1008);
      step(enc_i(7, 5'd0, 3'd0, 5'd5, 7'h13), 0);
      romout = enc_s(0, 5'd5, 5'd0, 3'd2);
      #1;
      chk("pre_we", {31'b0, memwrite}, 32'h1);
      rst = 1'b0;
      #1;
      chk("mid_we", {31'b0, memwrite}, 32'h0);
      chk("mid_pc", romaddr, 32'h0);
      chk("mid_be", {28'b0, iobytes}, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_x[i] = 0;
      rdreg(5'd5, v);
      chk("mid_x5", v, 32'h0);

      // Random instruction stream.
      do_reset();
      for (int i = 0; i < 600; i++)
         step(rand_ins(), $urandom);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
